// File: rtl/uart_tx_frame_if.sv
// Parallel-to-serial handshake between the system controller (master) and uart_tx_frame (slave).
// STP2 exists only when UART_TX_TWO_STOP_EN is defined.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
`ifdef UART_TX_TWO_STOP_EN
  logic                  STP2;
`endif
  logic                  TX_OUT;
  logic                  Busy;

`ifdef UART_TX_TWO_STOP_EN
  modport master (output P_DATA, output Data_Valid, output PAR_EN, output PAR_TYP,
                  output STP2, input TX_OUT, input Busy);
  modport slave  (input P_DATA, input Data_Valid, input PAR_EN, input PAR_TYP,
                  input STP2, output TX_OUT, output Busy);
`else
  modport master (output P_DATA, output Data_Valid, output PAR_EN, output PAR_TYP,
                  input TX_OUT, input Busy);
  modport slave  (input P_DATA, input Data_Valid, input PAR_EN, input PAR_TYP,
                  output TX_OUT, output Busy);
`endif
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, LSB-first data, optional parity, stop; one bit per CLK; Busy blocks new requests.
// Optional second stop bit via UART_TX_TWO_STOP_EN (adds STP2). Start bit appears on the edge that accepts Data_Valid.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_frame_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_q;
  logic                  busy_q;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stp2_q;
`endif

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stp2_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.Data_Valid) begin
            data_q    <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
`ifdef UART_TX_TWO_STOP_EN
            stp2_q    <= bus.STP2;
`endif
            state     <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          // Bit 0 goes out now; the shift register holds the remaining bits.
          state <= DATA;
          cnt   <= '0;
          tx_q  <= data_q[0];
          shreg <= data_q >> 1;
        end
        DATA: begin
          if (cnt == LAST_BIT) begin
            if (par_en_q) begin
              state <= PARITY;
              tx_q  <= par_bit_q;
            end else begin
              state <= STOP;
              tx_q  <= 1'b1;
            end
          end else begin
            cnt   <= cnt + 1'b1;
            tx_q  <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        PARITY: begin
          state <= STOP;
          tx_q  <= 1'b1;
        end
        STOP: begin
          tx_q <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
          if (stp2_q) begin
            stp2_q <= 1'b0;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
`else
          state  <= IDLE;
          busy_q <= 1'b0;
`endif
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: hand-computed TX_OUT sequences, checked on the falling edge.
module tb_uart_tx_frame;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starting just before the accept edge: seq[i] is TX_OUT in frame cycle i,
  // followed by one idle-high Busy=0 cycle. drop clears Data_Valid after accept;
  // disturb rewrites the inputs mid-frame.
  task automatic expect_frame(input string tag, input logic [15:0] seq, input int len,
                              input bit drop, input bit disturb);
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      check($sformatf("%s tx[%0d]", tag, i), {31'd0, bus.TX_OUT}, {31'd0, seq[i]});
      check($sformatf("%s busy[%0d]", tag, i), {31'd0, bus.Busy}, 32'd1);
      if (drop && i == 0) bus.Data_Valid = 1'b0;
      if (disturb && i == 2) begin
        bus.P_DATA     = 8'hC3;
        bus.PAR_TYP    = 1'b1;
        bus.Data_Valid = 1'b1;
      end
      if (disturb && i == 6) bus.Data_Valid = 1'b0;
    end
    @(negedge CLK);
    check({tag, " gap tx"}, {31'd0, bus.TX_OUT}, 32'd1);
    check({tag, " gap busy"}, {31'd0, bus.Busy}, 32'd0);
  endtask

  task automatic request(input logic [7:0] d, input logic pe, input logic pt);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
  endtask

  initial begin
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    bus.STP2       = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check("reset tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("reset busy", {31'd0, bus.Busy}, 32'd0);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("idle tx[%0d]", i), {31'd0, bus.TX_OUT}, 32'd1);
      check($sformatf("idle busy[%0d]", i), {31'd0, bus.Busy}, 32'd0);
    end

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    request(8'hA5, 1'b1, 1'b0);
    expect_frame("a5_even", 16'h054A, 11, 1'b1, 1'b0);

    // 0x00 odd parity: 0, eight 0s, parity 1, stop 1
    @(negedge CLK);
    request(8'h00, 1'b1, 1'b1);
    expect_frame("00_odd", 16'h0600, 11, 1'b1, 1'b0);

    // 0xFF no parity: 0, eight 1s, stop
    @(negedge CLK);
    request(8'hFF, 1'b0, 1'b0);
    expect_frame("ff_nopar", 16'h03FE, 10, 1'b1, 1'b0);

    // 0x3C even parity, inputs disturbed mid-frame
    @(negedge CLK);
    request(8'h3C, 1'b1, 1'b0);
    expect_frame("3c_stable", 16'h0478, 11, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("no_refire busy[%0d]", i), {31'd0, bus.Busy}, 32'd0);
      check($sformatf("no_refire tx[%0d]", i), {31'd0, bus.TX_OUT}, 32'd1);
    end

    // Back-to-back 0x5A, Data_Valid held high across two frames
    request(8'h5A, 1'b0, 1'b0);
    expect_frame("b2b_0", 16'h02B4, 10, 1'b0, 1'b0);
    expect_frame("b2b_1", 16'h02B4, 10, 1'b1, 1'b0);

    // Reset during DATA bit 3 (frame cycle 4)
    @(negedge CLK);
    request(8'hA5, 1'b1, 1'b0);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    check("pre_rst busy", {31'd0, bus.Busy}, 32'd1);
    repeat (4) @(negedge CLK);
    check("pre_rst bit3", {31'd0, bus.TX_OUT}, 32'd0);
    #1 RST = 1'b0;
    #1;
    check("mid_rst tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("mid_rst busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge CLK);
    check("mid_rst hold tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("mid_rst hold busy", {31'd0, bus.Busy}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("post_rst tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("post_rst busy", {31'd0, bus.Busy}, 32'd0);

    // 0x81 even parity: 0,1,0,0,0,0,0,0,1,0,1
    request(8'h81, 1'b1, 1'b0);
    expect_frame("81_even", 16'h0502, 11, 1'b1, 1'b0);

`ifdef UART_TX_TWO_STOP_EN
    // 0xFF no parity, two stop bits
    @(negedge CLK);
    request(8'hFF, 1'b0, 1'b0);
    bus.STP2 = 1'b1;
    expect_frame("ff_stp2", 16'h07FE, 11, 1'b1, 1'b0);
    bus.STP2 = 1'b0;
`endif

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter datapath and control for the UART block. It is the transmit-side counterpart of the RX start/parity/stop checkers. It accepts a parallel word with a valid strobe and serialises it LSB-first as start bit, data bits, optional parity bit and stop bit on TX_OUT. CLK is the baud-rate clock, so one CLK cycle equals one bit time. Its only client is the system controller, which must not present new data while Busy is high.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
CLK  input  1  baud-rate clock, rising edge.
RST  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  parallel word to transmit; sampled only on acceptance.
Data_Valid  input  1  request strobe; sampled only when Busy=0.
PAR_EN  input  1  1 = insert a parity bit after the data bits; sampled on acceptance.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
TX_OUT  output  1  serial line, registered, idle high.
Busy  output  1  registered; high for the whole frame.

Behaviour:
- Reset (RST=0): takes effect asynchronously. State=IDLE, TX_OUT=1, Busy=0, bit counter=0, data/parity registers=0. A frame in flight is aborted with no glitch low.
- FSM states: IDLE, START, DATA, PARITY, STOP. TX_OUT and Busy are registered and update on the same edge as the state.
- IDLE: TX_OUT=1, Busy=0. On an edge with Data_Valid=1:
  - latch P_DATA, PAR_EN and PAR_TYP;
  - compute the parity bit: even = XOR-reduce of P_DATA; odd = its inverse;
  - go to START; TX_OUT=0, Busy=1 from that edge.
- START lasts 1 cycle, then DATA with TX_OUT=data[0] and counter=0.
- DATA lasts DATA_WIDTH cycles. Each edge increments the counter and drives data[counter]; the shift register may be used instead, with identical output.
  - At counter=DATA_WIDTH-1: go to PARITY if the latched PAR_EN=1, else go to STOP.
- PARITY lasts 1 cycle with TX_OUT=latched parity bit, then STOP.
- STOP lasts 1 cycle with TX_OUT=1, Busy=1. On the next edge go to IDLE, Busy=0.
- Frame length: 2+DATA_WIDTH+PAR_EN cycles of Busy=1, measured from the accept edge.
- Data_Valid, P_DATA, PAR_EN and PAR_TYP are ignored while Busy=1; changing them mid-frame has no effect.
- Back-to-back: Data_Valid held high continuously gives a new start bit on the edge after Busy falls. The minimum gap is one idle-high cycle between frames.
- Counter width is $clog2(DATA_WIDTH) with no wrap beyond DATA_WIDTH-1. Unreachable state encodings recover to IDLE with TX_OUT=1.

Optional Feature:
UART_TX_TWO_STOP_EN.
- Defined:
  - adds an input port STP2 (1 bit), latched on acceptance;
  - when the latched STP2=1, STOP lasts 2 cycles (TX_OUT=1, Busy=1 throughout);
  - frame length becomes 2+DATA_WIDTH+PAR_EN+STP2.
- Undefined: the STP2 port is absent and exactly one stop bit is always sent.

Test Plan:
- Reset idle: hold RST=0, then release with Data_Valid=0 for 5 cycles -> TX_OUT=1, Busy=0 throughout.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Data_Valid pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, Busy=1 for exactly 11 cycles.
- Odd parity, no-parity case:
  - P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> 0, eight 0s, 1, 1;
  - P_DATA=0xFF, PAR_EN=0 -> 0, eight 1s, 1 over 10 cycles.
- Input stability: change P_DATA from 0x3C to 0xC3 and pulse Data_Valid mid-frame -> transmitted bits still encode 0x3C and no second frame starts.
- Back-to-back: Data_Valid held high with P_DATA=0x5A -> exactly one idle-high cycle with Busy=0 between consecutive frames, and each frame is correct.
- Mid-frame reset: assert RST=0 during the DATA bit 3 cycle -> TX_OUT=1 and Busy=0 immediately. After release, a new 0x81 frame is sent correctly.
